// File: rtl/freg_wb_arbiter_if.sv
// Writeback, issue-check and register-array signals of the FP register write-port controller.
// The slave modport is the controller; the master modport is the producer/issue side.
interface freg_wb_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  logic               issue_valid;
  logic [4:0]         issue_rd;
  logic [4:0]         chk_rs1;
  logic [4:0]         chk_rs2;
  logic [4:0]         chk_rs3;
  logic [4:0]         chk_rd;
  logic               hazard;
  logic [31:0]        busy;

  logic [DW-1:0]      G;
  logic [31:0]        F_in;
  logic [2:0]         byp_hit;
  logic [DW-1:0]      byp_data;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd,
           chk_rs1, chk_rs2, chk_rs3, chk_rd,
    input  req_ready, hazard, busy, G, F_in, byp_hit, byp_data
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd,
           chk_rs1, chk_rs2, chk_rs3, chk_rd,
    output req_ready, hazard, busy, G, F_in, byp_hit, byp_data
  );
endinterface

// File: rtl/freg_wb_arbiter.sv
// Round-robin writeback arbiter and busy scoreboard for the 32-entry FP register array.
// Optional bypass of the in-flight write to the source checks: define FREG_WB_BYPASS_EN.
module freg_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  freg_wb_arbiter_if.slave  bus
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RDW  = 5;
  localparam int unsigned NREG = 32;

  logic [PW-1:0]   r_ptr;
  logic [DW-1:0]   r_g;
  logic [NREG-1:0] r_f_in;
  logic [NREG-1:0] r_busy;

  logic [RDW-1:0]  w_lane_rd   [NREQ];
  logic [DW-1:0]   w_lane_data [NREQ];
  logic [PW:0]     w_cand;
  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_ready;
  logic [NREG-1:0] w_wr_onehot;
  logic [NREG-1:0] w_busy_nxt;
  logic [2:0]      w_byp_hit;

  // f0 is hardwired, so index 0 never produces an enable or a busy bit
  function automatic logic [NREG-1:0] f_onehot(input logic [RDW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    if (idx != '0) v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_lane_rd[gi]   = bus.req_rd[RDW*gi +: RDW];
    assign w_lane_data[gi] = bus.req_data[DW*gi +: DW];
  end

  // Scan requesters starting at the pointer; the first valid one wins
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_ready   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(NREQ)) w_cand = w_cand - (PW+1)'(NREQ);
      if (!w_gnt_vld && bus.req_valid[w_cand[PW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[PW-1:0];
      end
    end
    if (i_reset) w_gnt_vld = 1'b0;
    if (w_gnt_vld) w_ready[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_nxt   = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
  assign w_wr_onehot = w_gnt_vld ? f_onehot(w_lane_rd[w_gnt_idx]) : '0;

  // An issue on the same edge as the write clearing that index keeps it busy
  assign w_busy_nxt  = (r_busy & ~r_f_in) |
                       (bus.issue_valid ? f_onehot(bus.issue_rd) : '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr  <= '0;
      r_g    <= '0;
      r_f_in <= '0;
      r_busy <= '0;
    end else begin
      r_f_in <= w_wr_onehot;
      r_busy <= w_busy_nxt;
      if (w_gnt_vld) begin
        r_ptr <= w_ptr_nxt;
        r_g   <= w_lane_data[w_gnt_idx];
      end
    end
  end

`ifdef FREG_WB_BYPASS_EN
  // Sources matching the write on the array port this cycle read it from G
  always_comb begin
    w_byp_hit = '0;
    if (r_f_in != '0) begin
      w_byp_hit[0] = r_f_in[bus.chk_rs1];
      w_byp_hit[1] = r_f_in[bus.chk_rs2];
      w_byp_hit[2] = r_f_in[bus.chk_rs3];
    end
  end
  assign bus.byp_data = r_g;
`else
  assign w_byp_hit    = '0;
  assign bus.byp_data = '0;
`endif

  assign bus.hazard = (r_busy[bus.chk_rs1] & ~w_byp_hit[0]) |
                      (r_busy[bus.chk_rs2] & ~w_byp_hit[1]) |
                      (r_busy[bus.chk_rs3] & ~w_byp_hit[2]) |
                       r_busy[bus.chk_rd];

  assign bus.req_ready = w_ready;
  assign bus.busy      = r_busy;
  assign bus.G         = r_g;
  assign bus.F_in      = r_f_in;
  assign bus.byp_hit   = w_byp_hit;

endmodule

// File: tb/tb_freg_wb_arbiter.sv
// Bench for freg_wb_arbiter: arbitration vector table with a writeback scoreboard,
// plus hand sequences for reset, scoreboard set/clear, hazard and bypass.
module tb_freg_wb_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;

  typedef struct {
    logic [2:0] vld;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] rd2;
    logic [2:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] f;
    logic [31:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  freg_wb_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  freg_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  logic [2:0]  vld;
  logic [4:0]  rd_l [3];
  logic [31:0] d_l  [3];
  assign bus.req_valid = vld;
  assign bus.req_rd    = {rd_l[2], rd_l[1], rd_l[0]};
  assign bus.req_data  = {d_l[2], d_l[1], d_l[0]};

  int checks   = 0;
  int failures = 0;
  vec_t tbl [17];
  exp_t sb_q [$];
  exp_t e;
  logic [31:0] exp_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [4:0] rd, input int lane);
    if (rd == 5'd0) return 32'hDEADBEEF;
    return 32'hC000_0000 | (32'(rd) << 4) | 32'(lane);
  endfunction

  task automatic idle();
    vld = '0;
    for (int k = 0; k < 3; k++) begin
      rd_l[k] = '0;
      d_l[k]  = '0;
    end
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.chk_rs1     = '0;
    bus.chk_rs2     = '0;
    bus.chk_rs3     = '0;
    bus.chk_rd      = '0;
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b001};
    tbl[1]  = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b010};
    tbl[2]  = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b100};
    tbl[3]  = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b001};
    tbl[4]  = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b010};
    tbl[5]  = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b100};
    tbl[6]  = '{3'b000, 5'd0,  5'd0,  5'd0,  3'b000};
    tbl[7]  = '{3'b010, 5'd0,  5'd9,  5'd0,  3'b010};
    tbl[8]  = '{3'b101, 5'd6,  5'd0,  5'd7,  3'b100};
    tbl[9]  = '{3'b101, 5'd6,  5'd0,  5'd7,  3'b001};
    tbl[10] = '{3'b100, 5'd0,  5'd0,  5'd0,  3'b100};
    tbl[11] = '{3'b011, 5'd10, 5'd11, 5'd0,  3'b001};
    tbl[12] = '{3'b010, 5'd0,  5'd11, 5'd0,  3'b010};
    tbl[13] = '{3'b001, 5'd12, 5'd0,  5'd0,  3'b001};
    tbl[14] = '{3'b110, 5'd0,  5'd13, 5'd14, 3'b010};
    tbl[15] = '{3'b100, 5'd0,  5'd0,  5'd14, 3'b100};
    tbl[16] = '{3'b000, 5'd0,  5'd0,  5'd0,  3'b000};

    // Reset: outputs zero, requests not granted while reset is high
    idle();
    vld = 3'b111; rd_l[0] = 5'd1; rd_l[1] = 5'd2; rd_l[2] = 5'd3;
    #3;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_f_in", bus.F_in, 32'h0);
    chk("rst_g", bus.G, 32'h0);
    chk("rst_busy", bus.busy, 32'h0);
    chk("rst_hazard", 32'(bus.hazard), 32'h0);
    vld = '0;
    drive_cycle();
    reset = 1'b0;
    drive_cycle();
    @(negedge clk);
    chk("idle_f_in", bus.F_in, 32'h0);
    chk("idle_g", bus.G, 32'h0);
    chk("idle_busy", bus.busy, 32'h0);
    chk("idle_hazard", 32'(bus.hazard), 32'h0);

    // Issue rd=5, write it back two cycles later from the FPU
    drive_cycle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.chk_rs1 = 5'd5;
    drive_cycle();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    chk("rd5_busy_set", bus.busy, 32'h0000_0020);
    chk("rd5_hazard", 32'(bus.hazard), 32'h1);
    drive_cycle();
    vld = 3'b001; rd_l[0] = 5'd5; d_l[0] = 32'h3F80_0000;
    @(negedge clk);
    chk("rd5_ready", 32'(bus.req_ready), 32'h1);
    drive_cycle();
    vld = '0;
    @(negedge clk);
    chk("rd5_f_in", bus.F_in, 32'h0000_0020);
    chk("rd5_g", bus.G, 32'h3F80_0000);
    chk("rd5_busy_hold", bus.busy, 32'h0000_0020);
`ifdef FREG_WB_BYPASS_EN
    chk("rd5_byp_hit", 32'(bus.byp_hit), 32'h1);
    chk("rd5_byp_data", bus.byp_data, 32'h3F80_0000);
    chk("rd5_hazard_byp", 32'(bus.hazard), 32'h0);
`else
    chk("rd5_byp_hit", 32'(bus.byp_hit), 32'h0);
    chk("rd5_byp_data", bus.byp_data, 32'h0);
    chk("rd5_hazard_stall", 32'(bus.hazard), 32'h1);
`endif
    drive_cycle();
    @(negedge clk);
    chk("rd5_busy_clr", bus.busy, 32'h0);
    chk("rd5_f_in_done", bus.F_in, 32'h0);
    chk("rd5_g_hold", bus.G, 32'h3F80_0000);
    chk("rd5_hazard_clr", 32'(bus.hazard), 32'h0);

    // Reset asserted while a write is on the array port
    drive_cycle();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    drive_cycle();
    bus.issue_valid = 1'b0;
    vld = 3'b001; rd_l[0] = 5'd5; d_l[0] = 32'h1234_5678;
    drive_cycle();
    vld = '0;
    @(negedge clk);
    chk("mid_f_in_pre", bus.F_in, 32'h0000_0020);
    #1;
    reset = 1'b1;
    vld = 3'b001; rd_l[0] = 5'd9;
    #1;
    chk("mid_f_in_rst", bus.F_in, 32'h0);
    chk("mid_busy_rst", bus.busy, 32'h0);
    chk("mid_g_rst", bus.G, 32'h0);
    chk("mid_ready_rst", 32'(bus.req_ready), 32'h0);
    drive_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("mid_f_in_after", bus.F_in, 32'h0);

    // Arbitration table with writeback scoreboard
    exp_g = 32'h0;
    for (int i = 0; i < 17; i++) begin
      drive_cycle();
      vld     = tbl[i].vld;
      rd_l[0] = tbl[i].rd0;
      rd_l[1] = tbl[i].rd1;
      rd_l[2] = tbl[i].rd2;
      for (int k = 0; k < 3; k++) d_l[k] = mk_data(rd_l[k], k);
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("vec%0d_f_in", i), bus.F_in, e.f);
        chk($sformatf("vec%0d_g", i), bus.G, e.g);
      end
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_ready));
      e.f = 32'h0;
      for (int k = 0; k < 3; k++) begin
        if (tbl[i].exp_ready[k]) begin
          if (rd_l[k] != 5'd0) e.f = 32'h1 << rd_l[k];
          exp_g = d_l[k];
        end
      end
      e.g = exp_g;
      sb_q.push_back(e);
    end
    drive_cycle();
    idle();
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("drain_f_in", bus.F_in, e.f);
      chk("drain_g", bus.G, e.g);
    end
    chk("tbl_busy", bus.busy, 32'h0);

    // Hazard on busy[7] through each check port
    drive_cycle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    drive_cycle();
    bus.issue_valid = 1'b0; bus.chk_rs2 = 5'd7;
    @(negedge clk);
    chk("hz_busy7", bus.busy, 32'h0000_0080);
    chk("hz_rs2", 32'(bus.hazard), 32'h1);
    #1;
    bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd7;
    #1;
    chk("hz_rd", 32'(bus.hazard), 32'h1);
    bus.chk_rd = 5'd0; bus.chk_rs3 = 5'd7;
    #1;
    chk("hz_rs3", 32'(bus.hazard), 32'h1);
    bus.chk_rs3 = 5'd0;
    #1;
    chk("hz_none", 32'(bus.hazard), 32'h0);

    // Issue rd=4 on the edge that clears busy[4]: set wins
    drive_cycle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    drive_cycle();
    bus.issue_valid = 1'b0;
    vld = 3'b010; rd_l[1] = 5'd4; d_l[1] = 32'h4049_0FDB;
    @(negedge clk);
    chk("sw_ready", 32'(bus.req_ready), 32'h2);
    drive_cycle();
    vld = '0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.chk_rs1 = 5'd4;
    @(negedge clk);
    chk("sw_f_in", bus.F_in, 32'h0000_0010);
    chk("sw_busy_pre", bus.busy, 32'h0000_0090);
`ifdef FREG_WB_BYPASS_EN
    chk("sw_byp_hit", 32'(bus.byp_hit), 32'h1);
    chk("sw_byp_data", bus.byp_data, 32'h4049_0FDB);
    chk("sw_hazard_byp", 32'(bus.hazard), 32'h0);
`else
    chk("sw_byp_hit", 32'(bus.byp_hit), 32'h0);
    chk("sw_hazard_stall", 32'(bus.hazard), 32'h1);
`endif
    drive_cycle();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    chk("sw_busy_post", bus.busy, 32'h0000_0090);
    chk("sw_f_in_post", bus.F_in, 32'h0);
    chk("sw_byp_idle", 32'(bus.byp_hit), 32'h0);
    chk("sw_hazard_post", 32'(bus.hazard), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
